i2s_tx_stage: RTL and testbench



---
 rtl/i2s_tx_stage.sv | 183 ++++++++++++++++++
 tb/tb_i2s_tx_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_stage.sv
`default_nettype none
// ============================================================================
// Module : i2s_tx_stage
// Mono sample FIFO feeding a Philips-I2S serialiser (sample sent on L and R),
// with sticky overflow/underrun flags. Define I2S_TX_HOLD_ON_UNDERRUN_EN to
// repeat the previous sample on underrun instead of sending silence.
// Rev    : 1.0
// ============================================================================
module i2s_tx_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 24,
    parameter int BCLK_DIV   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               sample_valid,
    input  logic [DATA_WIDTH-1:0]              audio_in,
    input  logic                               enable,
    input  logic                               clear_status,
    output logic                               i2s_bclk,
    output logic                               i2s_lrclk,
    output logic                               i2s_sdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               overflow,
    output logic                               underrun
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] C_DIV_LAST   = DW'(BCLK_DIV - 1);
    localparam logic [LW-1:0] C_LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [5:0]    C_LAST_BIT   = 6'(OUT_WIDTH);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          div_q, div_d;
    logic                   bclk_q, bclk_d;
    logic [5:0]             bit_q, bit_d;
    logic                   lrclk_q, lrclk_d;
    logic                   sdata_q, sdata_d;
    logic [OUT_WIDTH-1:0]   hold_q, hold_d;
    logic [PW-1:0]          wptr_q, wptr_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   overflow_q, overflow_d;
    logic                   underrun_q, underrun_d;
    logic [OUT_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];

    logic                   w_empty, w_full, w_fall, w_frame_start, w_pop, w_wr;
    logic [OUT_WIDTH-1:0]   w_sample, w_head;

    // Slot bit 0 is the I2S one-bit delay; bits 1..OUT_WIDTH carry the sample MSB first.
    function automatic logic slot_bit(input logic [OUT_WIDTH-1:0] smp, input logic [5:0] b);
        logic [5:0]           s;
        logic [OUT_WIDTH-1:0] sh;
        s  = {1'b0, b[4:0]};
        sh = smp >> (C_LAST_BIT - s);
        return (s != 6'd0) && (s <= C_LAST_BIT) && sh[0];
    endfunction

    assign w_sample      = audio_in[DATA_WIDTH-1 -: OUT_WIDTH];
    assign w_head        = fifo_mem_q[rptr_q];
    assign w_empty       = (level_q == '0);
    assign w_full        = (level_q == C_LEVEL_FULL);
    assign w_fall        = (state_q == RUN) && enable && (div_q == C_DIV_LAST) && bclk_q;
    assign w_frame_start = ((state_q == IDLE) && enable) || (w_fall && (bit_q == 6'd63));
    assign w_pop         = w_frame_start && !w_empty;
    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign w_wr          = sample_valid && (!w_full || w_pop);

    generate
        if (DATA_WIDTH > OUT_WIDTH) begin : g_unused_lsbs
            logic w_unused_lsbs;
            assign w_unused_lsbs = ^audio_in[DATA_WIDTH-OUT_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bclk_d     = bclk_q;
        bit_d      = bit_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        hold_d     = hold_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;

        case (state_q)
            IDLE: begin
                div_d   = '0;
                bclk_d  = 1'b0;
                bit_d   = 6'd0;
                lrclk_d = 1'b0;
                sdata_d = 1'b0;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    div_d   = '0;
                    bclk_d  = 1'b0;
                    bit_d   = 6'd0;
                    lrclk_d = 1'b0;
                    sdata_d = 1'b0;
                end else if (div_q == C_DIV_LAST) begin
                    div_d  = '0;
                    bclk_d = !bclk_q;
                    // Data and word select move only on the falling bclk edge.
                    if (bclk_q) begin
                        bit_d   = bit_q + 6'd1;
                        lrclk_d = bit_d[5];
                        sdata_d = slot_bit(hold_q, bit_d);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_pop) begin
            hold_d = w_head;
        end else if (w_frame_start) begin
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
            hold_d = hold_q;
`else
            hold_d = '0;
`endif
        end

        if (w_wr)  wptr_d = wptr_q + PW'(1);
        if (w_pop) rptr_d = rptr_q + PW'(1);
        level_d    = level_q + LW'(w_wr) - LW'(w_pop);
        overflow_d = (sample_valid && w_full && !w_pop) || (overflow_q && !clear_status);
        underrun_d = (w_frame_start && w_empty) || (underrun_q && !clear_status);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bclk_q     <= 1'b0;
            bit_q      <= 6'd0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            hold_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            bit_q      <= bit_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            hold_q     <= hold_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) fifo_mem_q[wptr_q] <= w_sample;
    end

    assign i2s_bclk   = bclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sdata  = sdata_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign underrun   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_i2s_tx_stage
// Directed self-checking bench for i2s_tx_stage (BCLK_DIV=2, 24-bit slots).
// Rev    : 1.0
// ============================================================================
module tb_i2s_tx_stage;
    localparam int DATA_WIDTH = 32;
    localparam int OUT_WIDTH  = 24;
    localparam int BCLK_DIV   = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [31:0] audio_in = '0;
    logic        enable = 1'b0;
    logic        clear_status = 1'b0;
    logic        i2s_bclk, i2s_lrclk, i2s_sdata;
    logic [2:0]  fifo_level;
    logic        overflow, underrun;

    int vectors = 0;
    int miscompares = 0;

    i2s_tx_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .BCLK_DIV   (BCLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .audio_in     (audio_in),
        .enable       (enable),
        .clear_status (clear_status),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [23:0] smp, input int b);
        int s;
        s = b % 32;
        if (s >= 1 && s <= OUT_WIDTH) return smp[OUT_WIDTH - s];
        return 1'b0;
    endfunction

    task automatic write_sample(input logic [31:0] data);
        sample_valid = 1'b1;
        audio_in     = data;
        tick();
        sample_valid = 1'b0;
    endtask

    // Each bclk period is 4 clk: two low, two high. Called at the start of bit b_lo.
    task automatic play(input string tag, input logic [23:0] smp, input int b_lo, input int b_hi);
        for (int b = b_lo; b <= b_hi; b++) begin
            check($sformatf("%s_b%0d_bclk_lo", tag, b), {31'd0, i2s_bclk}, 32'd0);
            check($sformatf("%s_b%0d_lr_lo", tag, b), {31'd0, i2s_lrclk}, {31'd0, b >= 32});
            check($sformatf("%s_b%0d_sd_lo", tag, b), {31'd0, i2s_sdata}, {31'd0, exp_bit(smp, b)});
            tick(); tick();
            check($sformatf("%s_b%0d_bclk_hi", tag, b), {31'd0, i2s_bclk}, 32'd1);
            check($sformatf("%s_b%0d_lr_hi", tag, b), {31'd0, i2s_lrclk}, {31'd0, b >= 32});
            check($sformatf("%s_b%0d_sd_hi", tag, b), {31'd0, i2s_sdata}, {31'd0, exp_bit(smp, b)});
            tick(); tick();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_bclk"},  {31'd0, i2s_bclk},  32'd0);
        check({tag, "_lrclk"}, {31'd0, i2s_lrclk}, 32'd0);
        check({tag, "_sdata"}, {31'd0, i2s_sdata}, 32'd0);
    endtask

    logic [23:0] starve1_exp;
    logic [23:0] starve2_exp;

    initial begin
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
        starve1_exp = 24'h7FFFFF;
        starve2_exp = 24'hFEDCBA;
`else
        starve1_exp = 24'h000000;
        starve2_exp = 24'h000000;
`endif
        // Reset state
        #1;
        check_idle_outputs("rst");
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_udr", {31'd0, underrun}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check_idle_outputs("idle");

        // Single sample, full frame check
        write_sample(32'h7FFFFF00);
        check("w1_level", {29'd0, fifo_level}, 32'd1);
        enable = 1'b1;
        tick();
        check("f1_level", {29'd0, fifo_level}, 32'd0);
        check("f1_udr", {31'd0, underrun}, 32'd0);
        play("f1", 24'h7FFFFF, 0, 63);

        // FIFO now empty at the frame start
        check("f2_udr", {31'd0, underrun}, 32'd1);
        check("f2_level", {29'd0, fifo_level}, 32'd0);
        play("f2", starve1_exp, 0, 39);
        tick(); tick();
        check("drop_pre_bclk", {31'd0, i2s_bclk}, 32'd1);
        check("drop_pre_lr", {31'd0, i2s_lrclk}, 32'd1);
        enable = 1'b0;
        tick();
        check_idle_outputs("drop");
        tick();
        check_idle_outputs("drop2");

        // Overflow: five writes into a depth-4 FIFO
        write_sample(32'h12345678);
        check("ov_l1", {29'd0, fifo_level}, 32'd1);
        write_sample(32'h80000000);
        check("ov_l2", {29'd0, fifo_level}, 32'd2);
        write_sample(32'h00ABCDFF);
        check("ov_l3", {29'd0, fifo_level}, 32'd3);
        write_sample(32'hFEDCBA01);
        check("ov_l4", {29'd0, fifo_level}, 32'd4);
        check("ov_flag_pre", {31'd0, overflow}, 32'd0);
        write_sample(32'h55555555);
        check("ov_l5", {29'd0, fifo_level}, 32'd4);
        check("ov_flag", {31'd0, overflow}, 32'd1);

        // Set wins over clear, then a plain clear
        clear_status = 1'b1;
        write_sample(32'h66666666);
        check("clr_set_ovf", {31'd0, overflow}, 32'd1);
        check("clr_set_level", {29'd0, fifo_level}, 32'd4);
        tick();
        clear_status = 1'b0;
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        check("clr_udr", {31'd0, underrun}, 32'd0);

        // Re-enable: fresh pop at b=0, four queued frames, then starvation
        enable = 1'b1;
        tick();
        check("fa_level", {29'd0, fifo_level}, 32'd3);
        check("fa_udr", {31'd0, underrun}, 32'd0);
        play("fa", 24'h123456, 0, 63);
        check("fb_level", {29'd0, fifo_level}, 32'd2);
        play("fb", 24'h800000, 0, 63);
        check("fc_level", {29'd0, fifo_level}, 32'd1);
        play("fc", 24'h00ABCD, 0, 63);
        check("fd_level", {29'd0, fifo_level}, 32'd0);
        check("fd_udr", {31'd0, underrun}, 32'd0);
        play("fd", 24'hFEDCBA, 0, 63);
        check("fe_udr", {31'd0, underrun}, 32'd1);
        play("fe", starve2_exp, 0, 39);

        // Queue three samples mid-frame, then asynchronous reset
        write_sample(32'hAAAAAAAA);
        write_sample(32'hBBBBBBBB);
        write_sample(32'hCCCCCCCC);
        check("ar_pre_level", {29'd0, fifo_level}, 32'd3);
        check("ar_pre_bclk", {31'd0, i2s_bclk}, 32'd1);
        check("ar_pre_lr", {31'd0, i2s_lrclk}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("ar");
        check("ar_level", {29'd0, fifo_level}, 32'd0);
        check("ar_udr", {31'd0, underrun}, 32'd0);
        check("ar_ovf", {31'd0, overflow}, 32'd0);
        enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
